// File: rtl/ldpc_3gpp_dec_cnode_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_3gpp_dec_cnode_wr_pkg
// Brief    : Shared types and constants for the cnode RAM write stage.
// Revision : 1.0 - initial release
// ============================================================================
package ldpc_3gpp_dec_cnode_wr_pkg;

    localparam int cROW_BY_CYCLE = 8;
    localparam int cCOL_BY_CYCLE = 26;
    localparam int cLLR_BY_CYCLE = 1;
    localparam int cNODE_W       = 4;
    localparam int cSTATE_W      = 2;
    localparam int cHB_ROW_W     = 6;

    typedef logic [cNODE_W-1:0]   node_t;
    typedef logic [cSTATE_W-1:0]  node_state_t;
    typedef logic [cHB_ROW_W-1:0] hb_row_t;

    typedef struct packed {
        logic sof;
        logic sop;
        logic eop;
        logic eof;
    } strb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ldpc_3gpp_dec_cnode_wr_if.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_3gpp_dec_cnode_wr_if
// Brief    : Check-node word stream from the cnode engine array.
// Revision : 1.0 - initial release
// ============================================================================
interface ldpc_3gpp_dec_cnode_wr_if
    import ldpc_3gpp_dec_cnode_wr_pkg::*;
#(
    parameter int pDAT_W    = 832,
    parameter int pCSTATE_W = 416
) ();

    logic                 ival;
    strb_t                istrb;
    hb_row_t              irow;
    logic [pDAT_W-1:0]    icnode;
    logic [pCSTATE_W-1:0] icstate;

    modport master (
        output ival, istrb, irow, icnode, icstate
    );

    modport slave (
        input  ival, istrb, irow, icnode, icstate
    );

endinterface
`default_nettype wire

// File: rtl/ldpc_3gpp_dec_cnode_wr_addr.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_3gpp_dec_cnode_wr_addr
// Brief    : Word / row-base / bank counters and framing error compare.
// Revision : 1.0 - initial release
// ============================================================================
module ldpc_3gpp_dec_cnode_wr_addr
    import ldpc_3gpp_dec_cnode_wr_pkg::*;
#(
    parameter int pADDR_W = 9
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               istart,
    input  logic               iacc,
    input  logic               idone,
    input  strb_t              istrb,
    input  hb_row_t            irow,
    input  logic [pADDR_W-2:0] izc_words,
    input  hb_row_t            inrow,
    output logic [pADDR_W-1:0] oaddr,
    output logic [3:0]         oerr,
    output logic               owbank
);

    localparam int cOFS_W = pADDR_W - 1;

    logic [cOFS_W-1:0] r_word;
    logic [cOFS_W-1:0] r_row_base;
    hb_row_t           r_row;
    logic              r_wbank;

    logic [cOFS_W-1:0] w_word;
    logic [cOFS_W-1:0] w_row_base;
    logic [cOFS_W-1:0] w_ofs;
    hb_row_t           w_row;

    // sop/sof resynchronise the counters for the word being written
    always_comb begin
        w_word     = istrb.sop ? '0 : r_word;
        w_row_base = istrb.sof ? '0 : r_row_base;
        w_row      = istrb.sof ? '0 : r_row;
        w_ofs      = w_row_base + w_word;
        oerr[0]    = istrb.eop & (w_word != (izc_words - cOFS_W'(1)));
        oerr[1]    = istrb.sop & (r_word != '0);
        oerr[2]    = istrb.sop & (irow != w_row);
        oerr[3]    = istrb.eof & (w_row != (inrow - cHB_ROW_W'(1)));
    end

    assign oaddr  = {r_wbank, w_ofs};
    assign owbank = r_wbank;

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_word     <= '0;
            r_row_base <= '0;
            r_row      <= '0;
            r_wbank    <= 1'b0;
        end else if (iclkena) begin
            if (istart) begin
                r_word     <= '0;
                r_row_base <= '0;
                r_row      <= '0;
                r_wbank    <= 1'b0;
            end else if (iacc) begin
                if (istrb.eop) begin
                    r_word     <= '0;
                    r_row_base <= w_row_base + izc_words;
                    r_row      <= w_row + cHB_ROW_W'(1);
                end else begin
                    r_word     <= w_word + cOFS_W'(1);
                    r_row_base <= w_row_base;
                    r_row      <= w_row;
                end
                if (idone) begin
                    r_wbank <= ~r_wbank;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ldpc_3gpp_dec_cnode_wr.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_3gpp_dec_cnode_wr
// Brief    : Writes cnode words into a double-buffered RAM, tracks framing.
// Options  : LDPC_3GPP_DEC_CNODE_WR_SAT_CNT_EN adds the osat_cnt counter.
// Revision : 1.0 - initial release
// ============================================================================
module ldpc_3gpp_dec_cnode_wr
    import ldpc_3gpp_dec_cnode_wr_pkg::*;
#(
    parameter int pROW_BY_CYCLE = cROW_BY_CYCLE,
    parameter int pCOL_BY_CYCLE = cCOL_BY_CYCLE,
    parameter int pLLR_BY_CYCLE = cLLR_BY_CYCLE,
    parameter int pNODE_W       = cNODE_W,
    parameter int pSTATE_W      = cSTATE_W,
    parameter int pADDR_W       = 9,
    parameter int pITER_W       = 6,
    localparam int cNODES       = pROW_BY_CYCLE * pCOL_BY_CYCLE * pLLR_BY_CYCLE,
    localparam int cDAT_W       = cNODES * pNODE_W,
    localparam int cCSTATE_W    = cNODES * pSTATE_W
) (
    input  logic                  iclk,
    input  logic                  ireset,
    input  logic                  iclkena,
    input  logic                  istart,
    input  logic [pADDR_W-2:0]    izc_words,
    input  hb_row_t               inrow,
    ldpc_3gpp_dec_cnode_wr_if.slave s_if,
    output logic                  owrite,
    output logic [pADDR_W-1:0]    owaddr,
    output logic [cDAT_W-1:0]     owdat,
    output logic [cCSTATE_W-1:0]  owstate,
    output logic                  obank,
    output logic                  odone,
    output logic [pITER_W-1:0]    oiter,
    output logic [3:0]            oerr,
    output logic                  obusy
`ifdef LDPC_3GPP_DEC_CNODE_WR_SAT_CNT_EN
    ,
    output logic [15:0]           osat_cnt
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_acc;
    logic               w_done;
    strb_t              w_strb;
    logic [pADDR_W-1:0] w_addr;
    logic [3:0]         w_err;
    logic               w_wbank;

    assign w_strb = s_if.istrb;

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_state <= ST_IDLE;
        end else if (iclkena) begin
            r_state <= w_state_nxt;
        end
    end

    // istart wins over any coincident word
    always_comb begin
        w_state_nxt = r_state;
        w_acc       = 1'b0;
        w_done      = 1'b0;
        if (istart) begin
            w_state_nxt = ST_ARMED;
        end else if (s_if.ival) begin
            case (r_state)
                ST_ARMED: w_acc = w_strb.sof & w_strb.sop;
                ST_RUN:   w_acc = 1'b1;
                default:  w_acc = 1'b0;
            endcase
            w_done = w_acc & w_strb.eof & w_strb.eop;
            if (w_done) begin
                w_state_nxt = ST_ARMED;
            end else if (w_acc) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    ldpc_3gpp_dec_cnode_wr_addr #(
        .pADDR_W (pADDR_W)
    ) u_addr (
        .iclk      (iclk),
        .ireset    (ireset),
        .iclkena   (iclkena),
        .istart    (istart),
        .iacc      (w_acc),
        .idone     (w_done),
        .istrb     (w_strb),
        .irow      (s_if.irow),
        .izc_words (izc_words),
        .inrow     (inrow),
        .oaddr     (w_addr),
        .oerr      (w_err),
        .owbank    (w_wbank)
    );

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            owrite  <= 1'b0;
            owaddr  <= '0;
            owdat   <= '0;
            owstate <= '0;
            obank   <= 1'b0;
            odone   <= 1'b0;
            oiter   <= '0;
            oerr    <= '0;
        end else if (iclkena) begin
            owrite <= w_acc;
            odone  <= w_done;
            if (w_acc) begin
                owaddr  <= w_addr;
                owdat   <= s_if.icnode;
                owstate <= s_if.icstate;
            end
            if (istart) begin
                obank <= 1'b0;
                oiter <= '0;
                oerr  <= '0;
            end else if (w_acc) begin
                oerr <= oerr | w_err;
                if (w_done) begin
                    obank <= w_wbank;
                    if (oiter != {pITER_W{1'b1}}) begin
                        oiter <= oiter + pITER_W'(1);
                    end
                end
            end
        end
    end

    assign obusy = (r_state == ST_RUN);

`ifdef LDPC_3GPP_DEC_CNODE_WR_SAT_CNT_EN
    localparam logic [pNODE_W-1:0] cNODE_MIN = {1'b1, {(pNODE_W-1){1'b0}}};
    localparam logic [pNODE_W-1:0] cNODE_MAX = {1'b0, {(pNODE_W-1){1'b1}}};

    logic [15:0] r_sat_cnt;
    logic [15:0] w_sat_word;
    logic [16:0] w_sat_sum;

    always_comb begin
        w_sat_word = '0;
        for (int n = 0; n < cNODES; n++) begin
            if ((s_if.icnode[n*pNODE_W +: pNODE_W] == cNODE_MIN) ||
                (s_if.icnode[n*pNODE_W +: pNODE_W] == cNODE_MAX)) begin
                w_sat_word = w_sat_word + 16'd1;
            end
        end
        w_sat_sum = {1'b0, r_sat_cnt} + {1'b0, w_sat_word};
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_sat_cnt <= '0;
        end else if (iclkena) begin
            if (istart) begin
                r_sat_cnt <= '0;
            end else if (w_acc) begin
                r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
            end
        end
    end

    assign osat_cnt = r_sat_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ldpc_3gpp_dec_cnode_wr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ldpc_3gpp_dec_cnode_wr
// Brief    : Directed self-checking bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldpc_3gpp_dec_cnode_wr;
    import ldpc_3gpp_dec_cnode_wr_pkg::*;

    localparam int NV = 8 * 26 * 1;
    localparam int DW = NV * 4;
    localparam int SW = NV * 2;
    localparam int AW = 9;
    localparam int IW = 6;

    logic          iclk    = 1'b0;
    logic          ireset  = 1'b0;
    logic          iclkena = 1'b1;
    logic          istart  = 1'b0;
    logic [AW-2:0] izc_words = 8'd3;
    hb_row_t       inrow     = 6'd2;

    logic          owrite, obank, odone, obusy;
    logic [AW-1:0] owaddr;
    logic [DW-1:0] owdat;
    logic [SW-1:0] owstate;
    logic [IW-1:0] oiter;
    logic [3:0]    oerr;
`ifdef LDPC_3GPP_DEC_CNODE_WR_SAT_CNT_EN
    logic [15:0]   osat_cnt;
`endif

    ldpc_3gpp_dec_cnode_wr_if #(.pDAT_W(DW), .pCSTATE_W(SW)) s_if ();

    ldpc_3gpp_dec_cnode_wr dut (
        .iclk      (iclk),
        .ireset    (ireset),
        .iclkena   (iclkena),
        .istart    (istart),
        .izc_words (izc_words),
        .inrow     (inrow),
        .s_if      (s_if.slave),
        .owrite    (owrite),
        .owaddr    (owaddr),
        .owdat     (owdat),
        .owstate   (owstate),
        .obank     (obank),
        .odone     (odone),
        .oiter     (oiter),
        .oerr      (oerr),
        .obusy     (obusy)
`ifdef LDPC_3GPP_DEC_CNODE_WR_SAT_CNT_EN
        ,
        .osat_cnt  (osat_cnt)
`endif
    );

    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_errors = 0;
    bit gap      = 1'b0;
    bit last_ena = 1'b1;
    int n_done   = 0;
    int q_addr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level, plain integers) ----------
    int            m_state, m_word, m_base, m_row, m_bank;
    logic          e_write, e_done, e_bank, e_busy;
    int            e_addr, e_iter, e_sat;
    logic [3:0]    e_err;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_st;

    function automatic int count_sat(input logic [DW-1:0] d);
        int n = 0;
        for (int i = 0; i < NV; i++) begin
            if (d[i*4 +: 4] == 4'd7 || d[i*4 +: 4] == 4'd8) n++;
        end
        return n;
    endfunction

    always @(posedge iclk or negedge ireset) begin : b_model
        int   wd, bs, rw, zc, nr;
        logic acc, sof, sop, eop, eof;
        if (!ireset) begin
            m_state = 0; m_word = 0; m_base = 0; m_row = 0; m_bank = 0;
            e_write = 0; e_done = 0; e_bank = 0; e_busy = 0;
            e_addr = 0; e_iter = 0; e_sat = 0; e_err = 0; e_dat = '0; e_st = '0;
        end else if (iclkena) begin
            sof = s_if.istrb.sof; sop = s_if.istrb.sop;
            eop = s_if.istrb.eop; eof = s_if.istrb.eof;
            zc  = int'(izc_words); nr = int'(inrow);
            acc = 1'b0;
            e_done = 1'b0;
            if (istart) begin
                m_state = 1; m_word = 0; m_base = 0; m_row = 0; m_bank = 0;
                e_err = 0; e_iter = 0; e_bank = 0; e_sat = 0;
            end else if (s_if.ival) begin
                acc = (m_state == 2) || (m_state == 1 && sof && sop);
            end
            e_write = acc;
            if (acc) begin
                wd = sop ? 0 : m_word;
                bs = sof ? 0 : m_base;
                rw = sof ? 0 : m_row;
                e_addr = m_bank * 256 + (bs + wd) % 256;
                e_dat  = s_if.icnode;
                e_st   = s_if.icstate;
                if (eop && wd != zc - 1)          e_err[0] = 1'b1;
                if (sop && m_word != 0)           e_err[1] = 1'b1;
                if (sop && int'(s_if.irow) != rw) e_err[2] = 1'b1;
                if (eof && rw != nr - 1)          e_err[3] = 1'b1;
                e_sat = e_sat + count_sat(s_if.icnode);
                if (e_sat > 65535) e_sat = 65535;
                if (eop) begin
                    m_word = 0; m_base = (bs + zc) % 256; m_row = (rw + 1) % 64;
                end else begin
                    m_word = (wd + 1) % 256; m_base = bs; m_row = rw;
                end
                if (eof && eop) begin
                    e_done  = 1'b1;
                    e_bank  = m_bank[0];
                    m_bank  = 1 - m_bank;
                    e_iter  = (e_iter < 63) ? e_iter + 1 : 63;
                    m_state = 1;
                end else begin
                    m_state = 2;
                end
            end
            e_busy = (m_state == 2);
        end
    end

    always @(posedge iclk) last_ena <= iclkena;

    // ---------------- per-cycle compare ----------------
    always @(negedge iclk) begin
        if (ireset) begin
            chk("owrite", 32'(owrite), 32'(e_write));
            chk("odone",  32'(odone),  32'(e_done));
            chk("obank",  32'(obank),  32'(e_bank));
            chk("oiter",  32'(oiter),  32'(e_iter));
            chk("oerr",   32'(oerr),   32'(e_err));
            chk("obusy",  32'(obusy),  32'(e_busy));
            if (e_write) begin
                chk("owaddr", 32'(owaddr), 32'(e_addr));
                n_checks++;
                if (owdat !== e_dat || owstate !== e_st) begin
                    n_errors++;
                    $display("FAIL wdata: got %h expected %h", owdat, e_dat);
                end
            end
`ifdef LDPC_3GPP_DEC_CNODE_WR_SAT_CNT_EN
            chk("osat_cnt", 32'(osat_cnt), 32'(e_sat));
`endif
            if (owrite && last_ena) q_addr.push_back(int'(owaddr));
            if (odone && last_ena) n_done++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge iclk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [DW-1:0] mk_node(input int seed, input bit sat);
        logic [DW-1:0] d;
        for (int i = 0; i < NV; i++) begin
            if (sat) d[i*4 +: 4] = ((i + seed) % 2 == 1) ? 4'h7 : 4'h8;
            else     d[i*4 +: 4] = 4'((seed * 3 + i) % 16);
        end
        return d;
    endfunction

    function automatic logic [SW-1:0] mk_state(input int seed);
        logic [SW-1:0] d;
        for (int i = 0; i < NV; i++) d[i*2 +: 2] = 2'((seed + i) % 4);
        return d;
    endfunction

    task automatic word(input logic [3:0] s, input int row, input int seed, input bit sat);
        s_if.ival    = 1'b1;
        s_if.istrb   = s;
        s_if.irow    = 6'(row);
        s_if.icnode  = mk_node(seed, sat);
        s_if.icstate = mk_state(seed);
        if (gap) begin
            iclkena = 1'b0;
            tick();
        end
        iclkena = 1'b1;
        tick();
        s_if.ival = 1'b0;
    endtask

    task automatic send_frame(input int nrow, input int zc, input int seed, input bit sat);
        logic [3:0] s;
        for (int r = 0; r < nrow; r++) begin
            for (int w = 0; w < zc; w++) begin
                s[3] = (r == 0 && w == 0);
                s[2] = (w == 0);
                s[1] = (w == zc - 1);
                s[0] = (w == zc - 1 && r == nrow - 1);
                word(s, r, seed + r * zc + w, sat);
            end
        end
    endtask

    task automatic start(input int zc, input int nrow);
        izc_words = 8'(zc);
        inrow     = 6'(nrow);
        istart    = 1'b1;
        tick();
        istart    = 1'b0;
        q_addr.delete();
        n_done    = 0;
    endtask

    task automatic chk_list(input string name, input int exp [6], input int n);
        chk({name, "_count"}, 32'(q_addr.size()), 32'(n));
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            chk(name, 32'(q_addr[i]), 32'(exp[i]));
        end
        q_addr.delete();
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_owrite"}, 32'(owrite), 32'd0);
        chk({name, "_owaddr"}, 32'(owaddr), 32'd0);
        chk({name, "_owdat"},  32'(|owdat), 32'd0);
        chk({name, "_owstate"},32'(|owstate), 32'd0);
        chk({name, "_obank"},  32'(obank),  32'd0);
        chk({name, "_odone"},  32'(odone),  32'd0);
        chk({name, "_oiter"},  32'(oiter),  32'd0);
        chk({name, "_oerr"},   32'(oerr),   32'd0);
        chk({name, "_obusy"},  32'(obusy),  32'd0);
    endtask

    initial begin
        s_if.ival = 1'b0; s_if.istrb = '0; s_if.irow = '0;
        s_if.icnode = '0; s_if.icstate = '0;
        #1;
        chk_zero("reset");
        idle(2);
        ireset = 1'b1;
        tick();

        // normal frame, then second iteration into the other bank
        start(3, 2);
        send_frame(2, 3, 1, 1'b0);
        idle(2);
        chk_list("frame1_addr", '{0, 1, 2, 3, 4, 5}, 6);
        chk("frame1_done", 32'(n_done), 32'd1);
        chk("frame1_bank", 32'(obank), 32'd0);
        chk("frame1_iter", 32'(oiter), 32'd1);
        chk("frame1_err",  32'(oerr),  32'd0);
        n_done = 0;
        send_frame(2, 3, 20, 1'b0);
        idle(2);
        chk_list("frame2_addr", '{256, 257, 258, 259, 260, 261}, 6);
        chk("frame2_done", 32'(n_done), 32'd1);
        chk("frame2_bank", 32'(obank), 32'd1);
        chk("frame2_iter", 32'(oiter), 32'd2);

        // short row: eop after two words
        start(3, 2);
        word(4'b1100, 0, 40, 1'b0);
        word(4'b0010, 0, 41, 1'b0);
        word(4'b0100, 1, 42, 1'b0);
        word(4'b0000, 1, 43, 1'b0);
        word(4'b0011, 1, 44, 1'b0);
        idle(2);
        chk_list("short_addr", '{0, 1, 3, 4, 5, 0}, 5);
        chk("short_err", 32'(oerr), 32'h1);
        // wrong row index and early eof, previous bit stays set
        word(4'b1100, 5, 50, 1'b0);
        word(4'b0000, 0, 51, 1'b0);
        word(4'b0011, 0, 52, 1'b0);
        idle(2);
        chk("sticky_err", 32'(oerr), 32'hD);
        start(3, 2);
        chk("err_cleared", 32'(oerr), 32'h0);

        // single-word rows
        start(1, 2);
        word(4'b1110, 0, 60, 1'b0);
        word(4'b0111, 1, 61, 1'b0);
        idle(2);
        chk_list("zc1_addr", '{0, 1, 0, 0, 0, 0}, 2);
        chk("zc1_err", 32'(oerr), 32'h0);

        // asynchronous reset in the middle of a frame
        start(3, 2);
        word(4'b1100, 0, 70, 1'b0);
        word(4'b0000, 0, 71, 1'b0);
        word(4'b0010, 0, 72, 1'b0);
        word(4'b0100, 1, 73, 1'b0);
        #1 ireset = 1'b0;
        #1 chk_zero("midreset");
        tick();
        ireset = 1'b1;
        tick();
        word(4'b0100, 0, 74, 1'b0);
        chk("ignored_write", 32'(owrite), 32'd0);
        chk("ignored_busy",  32'(obusy),  32'd0);

        // istart coincident with a sof word
        istart = 1'b1;
        word(4'b1100, 0, 80, 1'b0);
        istart = 1'b0;
        chk("restart_write", 32'(owrite), 32'd0);
        chk("restart_busy",  32'(obusy),  32'd0);
        q_addr.delete();
        send_frame(2, 3, 81, 1'b0);
        idle(2);
        chk_list("restart_addr", '{0, 1, 2, 3, 4, 5}, 6);

        // saturated data with clock enable toggling
        start(3, 2);
        gap = 1'b1;
        send_frame(2, 3, 90, 1'b1);
        gap = 1'b0;
        idle(2);
        chk_list("gap_addr", '{0, 1, 2, 3, 4, 5}, 6);
        chk("gap_iter", 32'(oiter), 32'd1);
`ifdef LDPC_3GPP_DEC_CNODE_WR_SAT_CNT_EN
        chk("gap_sat", 32'(osat_cnt), 32'd1248);
`endif

        // iteration counter saturation
        start(2, 1);
        repeat (64) send_frame(1, 2, 100, 1'b0);
        idle(2);
        chk("iter_sat", 32'(oiter), 32'd63);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
